// File: rtl/pong_ball_ctrl.sv
// Pong ball/game controller: moves the ball once per frame, bounces it off walls and paddles,
// detects misses, keeps score and sequences serve/play/game-over. All outputs registered.
module pong_ball_ctrl #(
   parameter int H_VALID     = 640,
   parameter int V_VALID     = 480,
   parameter int BALL_SIZE   = 16,
   parameter int PADDLE_W    = 8,
   parameter int PADDLE_H    = 64,
   parameter int PADDLE_LX   = 16,
   parameter int PADDLE_RX   = 616,
   parameter int SPEED_INIT  = 2,
   parameter int SPEED_MAX   = 6,
   parameter int SERVE_DELAY = 60,
   parameter int WIN_SCORE   = 9
) (
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       hit,
   output logic       miss,
   output logic [2:0] state
);

   // state  | meaning
   // IDLE   | ball parked at centre, waiting for start
   // SERVE  | ball at centre, counting SERVE_DELAY frames
   // PLAY   | ball moves once per frame_tick
   // SCORED | one cycle after a miss: game over or re-serve
   // OVER   | everything frozen until start restarts the game
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SERVE  = 3'd1,
      S_PLAY   = 3'd2,
      S_SCORED = 3'd3,
      S_OVER   = 3'd4
   } state_t;

   localparam logic [9:0]  X_CENTRE   = 10'((H_VALID - BALL_SIZE) / 2);
   localparam logic [9:0]  Y_CENTRE   = 10'((V_VALID - BALL_SIZE) / 2);
   localparam logic [9:0]  X_LIMIT    = 10'(H_VALID - BALL_SIZE);
   localparam logic [9:0]  Y_LIMIT    = 10'(V_VALID - BALL_SIZE);
   localparam logic [9:0]  L_STOP     = 10'(PADDLE_LX + PADDLE_W);
   localparam logic [9:0]  R_STOP     = 10'(PADDLE_RX - BALL_SIZE);
   localparam logic [10:0] Y_LIMIT_W  = 11'(V_VALID - BALL_SIZE);
   localparam logic [10:0] H_VALID_W  = 11'(H_VALID);
   localparam logic [10:0] BALL_W     = 11'(BALL_SIZE);
   localparam logic [10:0] PAD_H_W    = 11'(PADDLE_H);
   localparam logic [10:0] L_FACE_W   = 11'(PADDLE_LX + PADDLE_W);
   localparam logic [10:0] R_FACE_W   = 11'(PADDLE_RX);
   localparam logic [3:0]  SPD_INIT   = 4'(SPEED_INIT);
   localparam logic [3:0]  SPD_MAX    = 4'(SPEED_MAX);
   localparam logic [5:0]  SERVE_LAST = 6'(SERVE_DELAY - 1);
   localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

   state_t      st_q, st_d;
   logic        dx_q, dx_d;
   logic        dy_q, dy_d;
   logic [3:0]  speed_q, speed_d;
   logic [5:0]  serve_cnt, serve_cnt_d;
   logic [9:0]  x_d, y_d;
   logic [3:0]  sl_d, sr_d;
   logic        hit_d, miss_d;

   logic [10:0] bx, by, sp, pl, pr;
   logic        ovl_l, ovl_r;
   logic [3:0]  speed_up;

   // 11-bit copies so every compare is free of wrap-around
   assign bx       = {1'b0, ball_x};
   assign by       = {1'b0, ball_y};
   assign sp       = {7'd0, speed_q};
   assign pl       = {1'b0, paddle_l_y};
   assign pr       = {1'b0, paddle_r_y};
   assign ovl_l    = (by + BALL_W > pl) && (by < pl + PAD_H_W);
   assign ovl_r    = (by + BALL_W > pr) && (by < pr + PAD_H_W);
   assign speed_up = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 4'd1;
   assign state    = st_q;

   always_comb begin
      st_d        = st_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      speed_d     = speed_q;
      serve_cnt_d = serve_cnt;
      x_d         = ball_x;
      y_d         = ball_y;
      sl_d        = score_l;
      sr_d        = score_r;
      hit_d       = 1'b0;
      miss_d      = 1'b0;
      case (st_q)
         S_IDLE: begin
            if (start) begin
               st_d        = S_SERVE;
               serve_cnt_d = '0;
            end
         end
         S_SERVE: begin
            if (frame_tick) begin
               serve_cnt_d = serve_cnt + 6'd1;
               if (serve_cnt == SERVE_LAST) st_d = S_PLAY;
            end
         end
         S_PLAY: begin
            if (frame_tick) begin
               if (dy_q) begin
                  if (by + sp >= Y_LIMIT_W) begin
                     y_d  = Y_LIMIT;
                     dy_d = 1'b0;
                  end else begin
                     y_d = 10'(by + sp);
                  end
               end else if (by <= sp) begin
                  y_d  = '0;
                  dy_d = 1'b1;
               end else begin
                  y_d = 10'(by - sp);
               end

               // paddle face test wins over the miss test
               if (!dx_q) begin
                  if ((bx - sp <= L_FACE_W) && (bx >= L_FACE_W) && ovl_l) begin
                     x_d     = L_STOP;
                     dx_d    = 1'b1;
                     hit_d   = 1'b1;
                     speed_d = speed_up;
                  end else if (bx <= sp) begin
                     x_d    = '0;
                     sr_d   = score_r + 4'd1;
                     miss_d = 1'b1;
                     st_d   = S_SCORED;
                  end else begin
                     x_d = 10'(bx - sp);
                  end
               end else begin
                  if ((bx + BALL_W + sp >= R_FACE_W) && (bx + BALL_W <= R_FACE_W) && ovl_r) begin
                     x_d     = R_STOP;
                     dx_d    = 1'b0;
                     hit_d   = 1'b1;
                     speed_d = speed_up;
                  end else if (bx + BALL_W + sp >= H_VALID_W) begin
                     x_d    = X_LIMIT;
                     sl_d   = score_l + 4'd1;
                     miss_d = 1'b1;
                     st_d   = S_SCORED;
                  end else begin
                     x_d = 10'(bx + sp);
                  end
               end
            end
         end
         S_SCORED: begin
            // dx still points at the player who conceded, so it is left as is
            if ((dx_q ? score_l : score_r) == WIN) begin
               st_d = S_OVER;
            end else begin
               st_d        = S_SERVE;
               x_d         = X_CENTRE;
               y_d         = Y_CENTRE;
               speed_d     = SPD_INIT;
               serve_cnt_d = '0;
            end
         end
         S_OVER: begin
            if (start) begin
               st_d        = S_SERVE;
               sl_d        = '0;
               sr_d        = '0;
               x_d         = X_CENTRE;
               y_d         = Y_CENTRE;
               speed_d     = SPD_INIT;
               serve_cnt_d = '0;
            end
         end
         default: st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         st_q      <= S_IDLE;
         dx_q      <= 1'b1;
         dy_q      <= 1'b1;
         speed_q   <= SPD_INIT;
         serve_cnt <= '0;
         ball_x    <= X_CENTRE;
         ball_y    <= Y_CENTRE;
         score_l   <= '0;
         score_r   <= '0;
         hit       <= 1'b0;
         miss      <= 1'b0;
      end else begin
         st_q      <= st_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         speed_q   <= speed_d;
         serve_cnt <= serve_cnt_d;
         ball_x    <= x_d;
         ball_y    <= y_d;
         score_l   <= sl_d;
         score_r   <= sr_d;
         hit       <= hit_d;
         miss      <= miss_d;
      end
   end

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Randomised bench for pong_ball_ctrl: a frame-level game model predicts every output each
// cycle, and a few hand-worked expectations pin the model to known positions and states.
module tb_pong_ball_ctrl;

   logic       vga_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic [9:0] paddle_l_y = '0;
   logic [9:0] paddle_r_y = '0;
   logic [9:0] ball_x, ball_y;
   logic [3:0] score_l, score_r;
   logic       hit, miss;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   pong_ball_ctrl dut (
      .vga_clk   (vga_clk),
      .sys_rst_n (sys_rst_n),
      .frame_tick(frame_tick),
      .start     (start),
      .paddle_l_y(paddle_l_y),
      .paddle_r_y(paddle_r_y),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .score_l   (score_l),
      .score_r   (score_r),
      .hit       (hit),
      .miss      (miss),
      .state     (state)
   );

   always #5 vga_clk = ~vga_clk;

   // game model: plain integer positions, a signed-free direction flag per axis
   int m_x = 312, m_y = 232, m_spd = 2, m_sl = 0, m_sr = 0, m_st = 0, m_cnt = 0;
   bit m_right = 1'b1, m_down = 1'b1, m_hit = 1'b0, m_miss = 1'b0;

   function automatic bit overlaps(int by, int p);
      return (by + 16 > p) && (by < p + 64);
   endfunction

   function automatic int faster(int s);
      return (s + 1 > 6) ? 6 : s + 1;
   endfunction

   always @(posedge vga_clk) begin : model
      int x0, y0, lead, nxt;
      m_hit  = 1'b0;
      m_miss = 1'b0;
      if (!sys_rst_n) begin
         m_x = 312; m_y = 232; m_right = 1'b1; m_down = 1'b1;
         m_spd = 2; m_sl = 0; m_sr = 0; m_st = 0; m_cnt = 0;
      end else begin
         case (m_st)
            0: if (start) begin m_st = 1; m_cnt = 0; end
            1: if (frame_tick) begin
                  m_cnt++;
                  if (m_cnt == 60) m_st = 2;
               end
            2: if (frame_tick) begin
                  x0 = m_x;
                  y0 = m_y;
                  if (m_down) begin
                     if (y0 + m_spd >= 464) begin m_y = 464; m_down = 1'b0; end
                     else m_y = y0 + m_spd;
                  end else begin
                     if (y0 - m_spd <= 0) begin m_y = 0; m_down = 1'b1; end
                     else m_y = y0 - m_spd;
                  end
                  if (m_right) begin
                     lead = x0 + 16;
                     nxt  = lead + m_spd;
                     if (lead <= 616 && nxt >= 616 && overlaps(y0, int'(paddle_r_y))) begin
                        m_x = 600; m_right = 1'b0; m_spd = faster(m_spd); m_hit = 1'b1;
                     end else if (nxt >= 640) begin
                        m_x = 624; m_sl++; m_miss = 1'b1; m_st = 3;
                     end else m_x = x0 + m_spd;
                  end else begin
                     nxt = x0 - m_spd;
                     if (x0 >= 24 && nxt <= 24 && overlaps(y0, int'(paddle_l_y))) begin
                        m_x = 24; m_right = 1'b1; m_spd = faster(m_spd); m_hit = 1'b1;
                     end else if (nxt <= 0) begin
                        m_x = 0; m_sr++; m_miss = 1'b1; m_st = 3;
                     end else m_x = nxt;
                  end
               end
            3: begin
                  if ((m_right ? m_sl : m_sr) == 9) m_st = 4;
                  else begin
                     m_st = 1; m_x = 312; m_y = 232; m_spd = 2; m_cnt = 0;
                  end
               end
            4: if (start) begin
                  m_sl = 0; m_sr = 0; m_x = 312; m_y = 232; m_spd = 2; m_st = 1; m_cnt = 0;
               end
            default: ;
         endcase
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge vga_clk) begin
      if (chk_en) begin
         check("ball_x",  int'(ball_x),  m_x);
         check("ball_y",  int'(ball_y),  m_y);
         check("score_l", int'(score_l), m_sl);
         check("score_r", int'(score_r), m_sr);
         check("hit",     int'(hit),     int'(m_hit));
         check("miss",    int'(miss),    int'(m_miss));
         check("state",   int'(state),   m_st);
      end
   end

   // paddle sometimes tracks the ball (hit likely), sometimes parks anywhere
   function automatic logic [9:0] pick_paddle(int by);
      int v;
      if ($urandom_range(0, 1) == 0) return 10'($urandom_range(0, 416));
      v = by + 16 - int'($urandom_range(0, 79));
      if (v < 0) v = 0;
      return 10'(v);
   endfunction

   task automatic do_tick();
      frame_tick = 1'b1;
      @(negedge vga_clk);
      frame_tick = 1'b0;
   endtask

   task automatic serve_ticks();
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge vga_clk);
         start = 1'($urandom_range(0, 1));
         if (i == 59) check("serve_before_last", int'(state), 1);
         do_tick();
      end
      start = 1'b0;
      check("serve_to_play", int'(state), 2);
      check("serve_x", int'(ball_x), 312);
      check("serve_y", int'(ball_y), 232);
   endtask

   initial begin
      repeat (3) @(negedge vga_clk);
      chk_en = 1'b1;
      check("rst_x", int'(ball_x), 312);
      check("rst_y", int'(ball_y), 232);
      check("rst_state", int'(state), 0);
      check("rst_scores", int'({score_l, score_r}), 0);
      check("rst_pulses", int'({hit, miss}), 0);
      sys_rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         frame_tick = 1'($urandom_range(0, 1));
         @(negedge vga_clk);
      end
      frame_tick = 1'b0;
      check("idle_hold", int'(state), 0);
      start = 1'b1;
      @(negedge vga_clk);
      start = 1'b0;
      check("idle_to_serve", int'(state), 1);

      serve_ticks();
      do_tick();
      check("first_move_x", int'(ball_x), 314);
      check("first_move_y", int'(ball_y), 234);

      for (int c = 0; c < 60000 && m_st != 4; c++) begin
         frame_tick = ($urandom_range(0, 3) != 0);
         start      = 1'($urandom_range(0, 1));
         paddle_l_y = pick_paddle(m_y);
         paddle_r_y = pick_paddle(m_y);
         @(negedge vga_clk);
      end
      start = 1'b0;
      frame_tick = 1'b0;
      check("reached_over", int'(state), 4);
      check("winner_nine", (score_l > score_r) ? int'(score_l) : int'(score_r), 9);

      for (int i = 0; i < 20; i++) begin
         frame_tick = 1'($urandom_range(0, 1));
         @(negedge vga_clk);
      end
      frame_tick = 1'b0;
      check("over_hold", int'(state), 4);

      start = 1'b1;
      @(negedge vga_clk);
      start = 1'b0;
      check("restart_state", int'(state), 1);
      check("restart_scores", int'({score_l, score_r}), 0);
      check("restart_x", int'(ball_x), 312);
      check("restart_y", int'(ball_y), 232);

      serve_ticks();
      for (int i = 0; i < 10; i++) begin
         paddle_l_y = pick_paddle(m_y);
         paddle_r_y = pick_paddle(m_y);
         do_tick();
      end
      check("mid_play", int'(state), 2);

      sys_rst_n  = 1'b0;
      frame_tick = 1'b1;
      start      = 1'b1;
      @(negedge vga_clk);
      frame_tick = 1'b0;
      start      = 1'b0;
      check("mid_rst_x", int'(ball_x), 312);
      check("mid_rst_y", int'(ball_y), 232);
      check("mid_rst_state", int'(state), 0);
      check("mid_rst_scores", int'({score_l, score_r}), 0);
      sys_rst_n = 1'b1;
      @(negedge vga_clk);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
